// File: rtl/seq_pkg.sv
// Shared types and defaults for the sequence value fetcher.
package seq_pkg;

  localparam int DEF_NUM_CHANNELS = 2;
  localparam int DEF_VALUE_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH   = 14;
  localparam int LAT_CNT_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_e;

  // LSB position of channel ch inside a packed BRAM word.
  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/seq_addr_wrap.sv
// Looping LUT address and completed-period counter, stepped by an advance strobe.
module seq_addr_wrap
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  clear_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] steps_per_period_i,
  input  logic [31:0]           num_periods_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           period_index_o,
  output logic                  complete_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           period_q, period_d;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [31:0]           period_inc;
  logic                  at_last;

  // A zero period length behaves as a single-entry period.
  assign last_addr  = (steps_per_period_i == '0) ? '0 : steps_per_period_i - 1'b1;
  assign at_last    = (addr_q == last_addr);
  assign period_inc = period_q + 32'd1;
  assign complete_o = at_last && (num_periods_i != 32'd0) && (period_inc == num_periods_i);

  always_comb begin
    addr_d   = addr_q;
    period_d = period_q;
    if (clear_i) begin
      addr_d   = '0;
      period_d = '0;
    end else if (advance_i) begin
      if (at_last) begin
        addr_d   = '0;
        period_d = period_inc;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      addr_q   <= '0;
      period_q <= '0;
    end else begin
      addr_q   <= addr_d;
      period_q <= period_d;
    end
  end

  assign addr_o         = addr_q;
  assign period_index_o = period_q;

endmodule

// File: rtl/sequence_value_fetcher.sv
// Maps stepper step advances onto a looping BRAM address and presents the fetched word.
// Optional SEQ_FETCHER_MISS_COUNT_EN adds a saturating missed_count output.
//
// state | meaning
// IDLE  | disabled; track step_counter, clear address and period count
// FETCH | one-cycle BRAM read strobe at current address
// WAIT  | count down BRAM read latency, then capture data
// HOLD  | value valid; watch step_counter for an advance
// DONE  | all periods completed; outputs cleared, steps ignored
module sequence_value_fetcher
  import seq_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int VALUE_WIDTH  = DEF_VALUE_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                                clk,
  input  logic                                areset,
  input  logic                                enable,
  input  logic [31:0]                         step_counter,
  input  logic [ADDR_WIDTH-1:0]               steps_per_period,
  input  logic [31:0]                         num_periods,
  output logic [ADDR_WIDTH-1:0]               bram_addr,
  output logic                                bram_en,
  input  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] bram_rdata,
  output logic [NUM_CHANNELS*VALUE_WIDTH-1:0] seq_value,
  output logic                                seq_valid,
  output logic                                seq_done,
  output logic                                step_missed,
  output logic [31:0]                         period_index
`ifdef SEQ_FETCHER_MISS_COUNT_EN
  ,
  output logic [31:0]                         missed_count
`endif
);

  localparam int DW = NUM_CHANNELS * VALUE_WIDTH;

  state_e               state_q, state_d;
  logic [31:0]          last_step_q, last_step_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [DW-1:0]        value_q, value_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 missed_q, missed_d;
  logic [31:0]          step_delta;
  logic                 clear_addr;
  logic                 advance;
  logic                 complete;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic [32:0]          miss_sum;
`endif

  assign step_delta = step_counter - last_step_q;

  seq_addr_wrap #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_wrap (
    .clk               (clk),
    .areset            (areset),
    .clear_i           (clear_addr),
    .advance_i         (advance),
    .steps_per_period_i(steps_per_period),
    .num_periods_i     (num_periods),
    .addr_o            (bram_addr),
    .period_index_o    (period_index),
    .complete_o        (complete)
  );

  always_comb begin
    state_d     = state_q;
    last_step_d = last_step_q;
    lat_cnt_d   = lat_cnt_q;
    value_d     = value_q;
    valid_d     = valid_q;
    done_d      = done_q;
    missed_d    = missed_q;
    clear_addr  = 1'b0;
    advance     = 1'b0;
    bram_en     = 1'b0;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
    miss_cnt_d  = miss_cnt_q;
    miss_sum    = {1'b0, miss_cnt_q} + {1'b0, step_delta - 32'd1};
`endif

    unique case (state_q)
      ST_IDLE: begin
        last_step_d = step_counter;
        clear_addr  = 1'b1;
        if (enable) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bram_en   = 1'b1;
        lat_cnt_d = LAT_CNT_W'(BRAM_LATENCY);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_d == '0) begin
          value_d = bram_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Only one LUT entry per observed change, however far the stepper jumped.
        if (step_delta != 32'd0) begin
          last_step_d = step_counter;
          advance     = 1'b1;
          if (step_delta > 32'd1) begin
            missed_d = 1'b1;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
            miss_cnt_d = miss_sum[32] ? '1 : miss_sum[31:0];
`endif
          end
          if (complete) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            value_d = '0;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d    = ST_IDLE;
      value_d    = '0;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      missed_d   = 1'b0;
      clear_addr = 1'b1;
      advance    = 1'b0;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
      miss_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      last_step_q <= '0;
      lat_cnt_q   <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      missed_q    <= 1'b0;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_step_q <= last_step_d;
      lat_cnt_q   <= lat_cnt_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign seq_value   = value_q;
  assign seq_valid   = valid_q;
  assign seq_done    = done_q;
  assign step_missed = missed_q;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
  assign missed_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sequence_value_fetcher.sv
// Self-checking bench for sequence_value_fetcher with a latency-accurate BRAM model.
module tb_sequence_value_fetcher;
  localparam int NCH = 2;
  localparam int VW  = 16;
  localparam int AW  = 14;
  localparam int LAT = 4;
  localparam int DW  = NCH * VW;

  logic          clk = 1'b0;
  logic          areset;
  logic          enable;
  logic [31:0]   step_counter;
  logic [AW-1:0] steps_per_period;
  logic [31:0]   num_periods;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] seq_value;
  logic          seq_valid;
  logic          seq_done;
  logic          step_missed;
  logic [31:0]   period_index;
`ifdef SEQ_FETCHER_MISS_COUNT_EN
  logic [31:0]   missed_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequence_value_fetcher #(
    .NUM_CHANNELS(NCH), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk             (clk),
    .areset          (areset),
    .enable          (enable),
    .step_counter    (step_counter),
    .steps_per_period(steps_per_period),
    .num_periods     (num_periods),
    .bram_addr       (bram_addr),
    .bram_en         (bram_en),
    .bram_rdata      (bram_rdata),
    .seq_value       (seq_value),
    .seq_valid       (seq_valid),
    .seq_done        (seq_done),
    .step_missed     (step_missed),
    .period_index    (period_index)
`ifdef SEQ_FETCHER_MISS_COUNT_EN
    ,
    .missed_count    (missed_count)
`endif
  );

  // Word i: channel 0 = i*0x0101, channel 1 = that value xor 0xA5A5.
  function automatic logic [DW-1:0] word_at(input int a);
    logic [15:0] lo;
    lo = 16'(a * 32'h0101);
    return {lo ^ 16'hA5A5, lo};
  endfunction

  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (bram_en) pipe[0] <= word_at(int'(bram_addr));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata = pipe[LAT-1];

  task automatic run_step(input logic [31:0] s, input int cycles,
                          output int fetches, output int faddr, output bit dropped);
    step_counter = s;
    fetches = 0; faddr = -1; dropped = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bram_en) begin fetches++; faddr = int'(bram_addr); end
      if (!seq_valid) dropped = 1'b1;
    end
  endtask

  task automatic restart(input int spp, input logic [31:0] np, input logic [31:0] s0);
    enable = 1'b0;
    steps_per_period = AW'(spp);
    num_periods = np;
    step_counter = s0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b0; step_counter = '0;
    steps_per_period = AW'(4); num_periods = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (bram_addr !== '0)     begin errors++; $display("FAIL reset_bram_addr got=%0h exp=0", bram_addr); end
    checks++; if (bram_en !== 1'b0)     begin errors++; $display("FAIL reset_bram_en got=%0b exp=0", bram_en); end
    checks++; if (seq_value !== '0)     begin errors++; $display("FAIL reset_seq_value got=%0h exp=0", seq_value); end
    checks++; if (seq_valid !== 1'b0)   begin errors++; $display("FAIL reset_seq_valid got=%0b exp=0", seq_valid); end
    checks++; if (seq_done !== 1'b0)    begin errors++; $display("FAIL reset_seq_done got=%0b exp=0", seq_done); end
    checks++; if (step_missed !== 1'b0) begin errors++; $display("FAIL reset_step_missed got=%0b exp=0", step_missed); end
    checks++; if (period_index !== '0)  begin errors++; $display("FAIL reset_period_index got=%0h exp=0", period_index); end
    areset = 1'b0;
    @(negedge clk);
    checks++; if (bram_en !== 1'b0)     begin errors++; $display("FAIL idle_bram_en got=%0b exp=0", bram_en); end
  endtask

  task automatic test_first_fetch();
    enable = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (bram_en !== 1'b1) begin errors++; $display("FAIL first_bram_en got=%0b exp=1", bram_en); end
        checks++; if (bram_addr !== '0) begin errors++; $display("FAIL first_bram_addr got=%0h exp=0", bram_addr); end
      end
      if (c == LAT + 1) begin
        checks++; if (seq_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early got=%0b exp=0 cycle=%0d", seq_valid, c); end
      end
      if (c == LAT + 2) begin
        checks++; if (seq_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b exp=1 cycle=%0d", seq_valid, c); end
        checks++; if (seq_value !== word_at(0)) begin errors++; $display("FAIL first_value got=%0h exp=%0h", seq_value, word_at(0)); end
      end
    end
  endtask

  task automatic test_looping();
    int f, a; bit d;
    for (int k = 1; k <= 9; k++) begin
      run_step(32'(k), 10, f, a, d);
      checks++; if (f != 1 || a != k % 4) begin errors++; $display("FAIL loop_fetch step=%0d got_n=%0d got_addr=%0d exp_addr=%0d", k, f, a, k % 4); end
      checks++; if (d) begin errors++; $display("FAIL loop_valid_drop step=%0d got=dropped exp=held", k); end
      checks++; if (seq_value !== word_at(k % 4)) begin errors++; $display("FAIL loop_value step=%0d got=%0h exp=%0h", k, seq_value, word_at(k % 4)); end
      checks++; if (period_index !== 32'(k / 4)) begin errors++; $display("FAIL loop_period step=%0d got=%0d exp=%0d", k, period_index, k / 4); end
    end
    checks++; if (step_missed !== 1'b0) begin errors++; $display("FAIL loop_missed got=%0b exp=0", step_missed); end
  endtask

  task automatic test_done();
    int f, a; bit d;
    restart(3, 32'd2, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      run_step(32'(k), 10, f, a, d);
      checks++; if (f != ((k < 6) ? 1 : 0)) begin errors++; $display("FAIL done_fetches step=%0d got=%0d", k, f); end
      checks++; if (seq_done !== (k >= 6)) begin errors++; $display("FAIL done_flag step=%0d got=%0b exp=%0b", k, seq_done, k >= 6); end
      if (k >= 6) begin
        checks++; if (seq_valid !== 1'b0 || seq_value !== '0) begin errors++; $display("FAIL done_outputs step=%0d valid=%0b value=%0h exp=0/0", k, seq_valid, seq_value); end
        checks++; if (period_index !== 32'd2) begin errors++; $display("FAIL done_period got=%0d exp=2", period_index); end
      end else begin
        checks++; if (seq_value !== word_at(k % 3)) begin errors++; $display("FAIL done_value step=%0d got=%0h exp=%0h", k, seq_value, word_at(k % 3)); end
      end
    end
  endtask

  task automatic test_missed();
    int f, a; bit d;
    restart(4, 32'd0, 32'd0);
    for (int k = 1; k <= 5; k++) run_step(32'(k), 10, f, a, d);
    checks++; if (step_missed !== 1'b0) begin errors++; $display("FAIL miss_before got=%0b exp=0", step_missed); end
    run_step(32'd8, 10, f, a, d);
    checks++; if (f != 1 || a != 2) begin errors++; $display("FAIL miss_addr got_n=%0d got=%0d exp=2", f, a); end
    checks++; if (step_missed !== 1'b1) begin errors++; $display("FAIL miss_flag got=%0b exp=1", step_missed); end
    checks++; if (seq_value !== word_at(2)) begin errors++; $display("FAIL miss_value got=%0h exp=%0h", seq_value, word_at(2)); end
`ifdef SEQ_FETCHER_MISS_COUNT_EN
    checks++; if (missed_count !== 32'd2) begin errors++; $display("FAIL miss_count got=%0d exp=2", missed_count); end
`endif
    run_step(32'd9, 10, f, a, d);
    checks++; if (step_missed !== 1'b1 || a != 3) begin errors++; $display("FAIL miss_sticky flag=%0b addr=%0d exp=1/3", step_missed, a); end
  endtask

  task automatic test_step_in_wait();
    int f, a0, a1; bit d;
    restart(4, 32'd0, 32'd10);
    step_counter = 32'd11;
    f = 0; a0 = -1; a1 = -1; d = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bram_en) begin
        if (f == 0) a0 = int'(bram_addr); else a1 = int'(bram_addr);
        f++;
      end
      if (!seq_valid) d = 1'b1;
      if (i == 2) step_counter = 32'd12;
    end
    checks++; if (f != 2 || a0 != 1 || a1 != 2) begin errors++; $display("FAIL wait_step got_n=%0d addrs=%0d,%0d exp=2 fetches 1,2", f, a0, a1); end
    checks++; if (d) begin errors++; $display("FAIL wait_valid_drop got=dropped exp=held"); end
    checks++; if (seq_value !== word_at(2)) begin errors++; $display("FAIL wait_value got=%0h exp=%0h", seq_value, word_at(2)); end
    checks++; if (step_missed !== 1'b0) begin errors++; $display("FAIL wait_missed got=%0b exp=0", step_missed); end
  endtask

  task automatic test_enable_drop();
    int f, a; bit d;
    restart(4, 32'd0, 32'd0);
    run_step(32'd1, 10, f, a, d);
    run_step(32'd3, 10, f, a, d);
    step_counter = 32'd4;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (seq_valid !== 1'b0 || seq_value !== '0) begin errors++; $display("FAIL drop_outputs valid=%0b value=%0h exp=0/0", seq_valid, seq_value); end
    checks++; if (step_missed !== 1'b0 || seq_done !== 1'b0) begin errors++; $display("FAIL drop_flags missed=%0b done=%0b exp=0/0", step_missed, seq_done); end
    @(negedge clk);
    checks++; if (period_index !== '0) begin errors++; $display("FAIL drop_period got=%0d exp=0", period_index); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (bram_en !== 1'b1 || bram_addr !== '0) begin errors++; $display("FAIL drop_refetch en=%0b addr=%0h exp=1/0", bram_en, bram_addr); end
    repeat (LAT + 1) @(negedge clk);
    checks++; if (seq_valid !== 1'b1 || seq_value !== word_at(0)) begin errors++; $display("FAIL drop_reload valid=%0b value=%0h exp=%0h", seq_valid, seq_value, word_at(0)); end
    run_step(32'd5, 10, f, a, d);
    checks++; if (a != 1) begin errors++; $display("FAIL drop_next_addr got=%0d exp=1", a); end
  endtask

  task automatic test_areset_mid_hold();
    int f, a; bit d;
    restart(4, 32'd0, 32'd0);
    run_step(32'd1, 10, f, a, d);
    run_step(32'd2, 10, f, a, d);
    run_step(32'd4, 10, f, a, d);
    run_step(32'd5, 10, f, a, d);
    #2 areset = 1'b1;
    #1;
    checks++; if (seq_value !== '0 || seq_valid !== 1'b0) begin errors++; $display("FAIL areset_value valid=%0b value=%0h exp=0/0", seq_valid, seq_value); end
    checks++; if (step_missed !== 1'b0 || seq_done !== 1'b0) begin errors++; $display("FAIL areset_flags missed=%0b done=%0b exp=0/0", step_missed, seq_done); end
    checks++; if (period_index !== '0 || bram_addr !== '0 || bram_en !== 1'b0) begin errors++; $display("FAIL areset_addr period=%0d addr=%0h en=%0b exp=0", period_index, bram_addr, bram_en); end
    @(negedge clk);
    areset = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    checks++; if (seq_valid !== 1'b1 || seq_value !== word_at(0)) begin errors++; $display("FAIL areset_resume valid=%0b value=%0h exp=%0h", seq_valid, seq_value, word_at(0)); end
  endtask

  task automatic test_wrap_step();
    int f, a; bit d;
    restart(4, 32'd0, 32'hFFFF_FFFF);
    run_step(32'd0, 10, f, a, d);
    checks++; if (f != 1 || a != 1) begin errors++; $display("FAIL wrap_addr got_n=%0d got=%0d exp=1", f, a); end
    checks++; if (step_missed !== 1'b0) begin errors++; $display("FAIL wrap_missed got=%0b exp=0", step_missed); end
  endtask

  task automatic test_spp_zero();
    int f, a; bit d;
    restart(0, 32'd3, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      run_step(32'(k), 10, f, a, d);
      checks++; if (period_index !== 32'((k < 3) ? k : 3)) begin errors++; $display("FAIL spp0_period step=%0d got=%0d", k, period_index); end
      checks++; if (seq_done !== (k >= 3)) begin errors++; $display("FAIL spp0_done step=%0d got=%0b", k, seq_done); end
      if (k < 3) begin
        checks++; if (f != 1 || a != 0) begin errors++; $display("FAIL spp0_addr step=%0d got_n=%0d got=%0d exp=0", k, f, a); end
      end
    end
  endtask

  task automatic test_random();
    int f, a; bit d;
    int spp, k, inc, exp_f;
    logic [31:0] np, s;
    bit done, missed;
    longint msum;
    for (int r = 0; r < 3; r++) begin
      spp = int'($urandom_range(1, 6));
      np  = (r == 0) ? 32'd0 : 32'($urandom_range(1, 4));
      s   = $urandom;
      restart(spp, np, s);
      k = 0; done = 1'b0; missed = 1'b0; msum = 0;
      for (int n = 0; n < 25; n++) begin
        inc = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
        s = s + 32'(inc);
        exp_f = 0;
        if (!done && inc != 0) begin
          k++;
          if (inc > 1) begin missed = 1'b1; msum += inc - 1; end
          if (np != 0 && k == spp * int'(np)) done = 1'b1;
          else exp_f = 1;
        end
        run_step(s, 10, f, a, d);
        checks++; if (f != exp_f || (exp_f == 1 && a != k % spp)) begin errors++; $display("FAIL rand_fetch r=%0d n=%0d got_n=%0d got=%0d exp_n=%0d exp=%0d", r, n, f, a, exp_f, k % spp); end
        checks++; if (seq_done !== done || step_missed !== missed) begin errors++; $display("FAIL rand_flags r=%0d n=%0d done=%0b missed=%0b exp=%0b/%0b", r, n, seq_done, step_missed, done, missed); end
        checks++; if (period_index !== 32'(k / spp)) begin errors++; $display("FAIL rand_period r=%0d n=%0d got=%0d exp=%0d", r, n, period_index, k / spp); end
        checks++; if (seq_value !== (done ? '0 : word_at(k % spp)) || seq_valid !== !done) begin errors++; $display("FAIL rand_value r=%0d n=%0d got=%0h valid=%0b", r, n, seq_value, seq_valid); end
`ifdef SEQ_FETCHER_MISS_COUNT_EN
        checks++; if (missed_count !== 32'(msum)) begin errors++; $display("FAIL rand_miss_count got=%0d exp=%0d", missed_count, msum); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_looping();
    test_done();
    test_missed();
    test_step_in_wait();
    test_enable_drop();
    test_areset_mid_hold();
    test_wrap_step();
    test_spp_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_value_fetcher.md
Name: sequence_value_fetcher

Overview:
Downstream consumer of the sequence stepper's step counter. Tracks each step advance, maps the absolute step index onto a looping LUT address (steps-per-period, repetitions) and fetches the per-channel sequence word from the sequence BRAM. Presents a registered, valid-qualified value to the DAC/offset stage. Flags end-of-sequence and late (skipped) steps.

Parameters:
NUM_CHANNELS, 2, channels packed per BRAM word
VALUE_WIDTH, 16, bits per channel value
ADDR_WIDTH, 14, BRAM address width
BRAM_LATENCY, 2, read latency in cycles (allowed range 1-4)

Ports:
clk  in  1  system clock
areset  in  1  asynchronous reset, active-high
enable  in  1  run enable; low forces IDLE
step_counter  in  32  step index from the sequence stepper
steps_per_period  in  ADDR_WIDTH  LUT entries per period (0 is treated as 1)
num_periods  in  32  period repetitions; 0 = loop forever
bram_addr  out  ADDR_WIDTH  BRAM read address
bram_en  out  1  BRAM read strobe
bram_rdata  in  NUM_CHANNELS*VALUE_WIDTH  BRAM read data
seq_value  out  NUM_CHANNELS*VALUE_WIDTH  current sequence value, channel 0 in LSBs
seq_valid  out  1  seq_value holds data for the current step
seq_done  out  1  all periods completed (sticky until enable low)
step_missed  out  1  sticky: step_counter advanced by more than 1 between samples
period_index  out  32  completed-period count

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (areset).
- Reset values: bram_addr=0, bram_en=0, seq_value=0, seq_valid=0, seq_done=0, step_missed=0, period_index=0, FSM=IDLE.
- FSM states: IDLE, FETCH, WAIT, HOLD, DONE.
- IDLE: last_step <= step_counter, addr=0, period_index=0. On enable=1 go to FETCH; the entry for step 0 is fetched immediately.
- FETCH: drive bram_addr=addr and bram_en=1 for 1 cycle. Load latency counter with BRAM_LATENCY. Go to WAIT.
- WAIT: decrement the counter. At 0, capture bram_rdata into seq_value, set seq_valid=1, go to HOLD.
  - Latency from FETCH entry to seq_valid: BRAM_LATENCY+1 cycles.
- HOLD: compare step_counter against last_step (32-bit, modulo 2^32 difference d).
  - d=0: stay.
  - d>=1: last_step <= step_counter, advance addr by one.
  - d>1: additionally set step_missed. Still advance by exactly one entry, never by d.
- Address advance:
  - if addr == steps_per_period-1: addr <= 0 and period_index += 1.
  - else addr += 1.
  - No division/modulo.
- Period completion: when the advance makes period_index == num_periods and num_periods != 0, go to DONE. Otherwise go to FETCH.
  - seq_valid stays 1 through FETCH/WAIT; the old value is held until replaced. No glitch to 0.
- DONE: seq_done=1, seq_valid=0, seq_value=0, bram_en=0. Further step changes are ignored.
- enable low in any state: next cycle go to IDLE, seq_valid=0, seq_value=0, seq_done=0, step_missed=0. An in-flight BRAM read is discarded.
- Step change during FETCH/WAIT: it is not lost. It is compared on HOLD entry because last_step is only updated in HOLD.
- step_counter wrap 0xFFFFFFFF -> 0: d=1, a normal advance.
- steps_per_period=0: behaves as 1, so addr is always 0 and every step completes a period.
- areset mid-operation: all outputs return to reset values asynchronously.

Optional Feature:
- Macro: SEQ_FETCHER_MISS_COUNT_EN.
- Defined:
  - Adds output missed_count [31:0], a saturating count of the total skipped steps (sum of d-1 over all advances).
  - Reset and enable-low clear it to 0.
- Undefined: port absent; only the sticky step_missed flag exists.

Decomposition:
- Shared package seq_pkg:
  - FSM state enum (IDLE/FETCH/WAIT/HOLD/DONE).
  - VALUE_WIDTH/ADDR_WIDTH defaults.
  - Channel-slice helper constant.
- Natural sub-module: seq_addr_wrap. Holds the addr/period_index counters with the wrap and completion compare, driven by an advance strobe.

Test Plan:
- Reset then enable=1, steps_per_period=4, num_periods=0, BRAM[i]=i*0x0101 -> bram_addr=0 on cycle 1; seq_value=0x0000 valid at cycle BRAM_LATENCY+2.
- Increment step_counter 0..9 one per 10 cycles -> bram_addr sequence 0,1,2,3,0,1,2,3,0,1; period_index=2 after step 8; step_missed=0.
- steps_per_period=3, num_periods=2, steps 0..6 -> seq_done=1 after step 6; seq_valid=0; seq_value=0; step 7 ignored.
- Step jump 5 -> 8 in HOLD -> step_missed=1; addr advances by one only; with SEQ_FETCHER_MISS_COUNT_EN, missed_count=2.
- Step change while in WAIT (BRAM_LATENCY=4) -> on HOLD entry one advance occurs; no step lost; seq_valid never drops.
- enable low mid-WAIT, then high -> outputs cleared; refetch starts at addr 0. A separate check asserts areset mid-HOLD and expects immediate clear of all outputs.
